counter_monitor: RTL
====================

# counter_monitor

Self-checking observer for the 4-bit ripple counter output: samples the counter value every clock, locks onto the incrementing sequence, and flags any value that is not the previous sample plus one, modulo 2^WIDTH. It sits beside the counter and the stimulus driver on the shared `clk`/`rst`/`q` nets. It is the reading end of the interface the stimulus drives. Its error and wrap counters let a regression pass or fail without waveform inspection.

## Interface
- `WIDTH`, 4, width of the observed counter value.
- `LOCK_CNT`, 2, consecutive correct increments required to declare lock (legal range 1..15).
- `ERR_W`, 8, width of the error and wrap counters.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `q` input WIDTH: observed counter value. The counter changes on the falling edge, so `q` is settled at each rising edge.
- `clr` input 1: synchronous, active-high clear of `err_sticky`, `err_cnt` and `wrap_cnt`.
- `locked` output 1: high while in TRACK.
- `err` output 1: one-cycle pulse per mismatch detected in TRACK.
- `err_sticky` output 1: set by any `err`; held until `clr` or reset.
- `err_cnt` output ERR_W: mismatch count; saturates at 2^ERR_W-1.
- `wrap_cnt` output ERR_W: count of max-to-0 wraps seen in TRACK; saturates at 2^ERR_W-1.

## Operation
- Internal registers:
  - `prev` (WIDTH bits): previous sample.
  - `good` (4 bits): correct-increment run length.
  - `state`: IDLE, SYNC or TRACK.
- `next = prev + 1`, truncated to WIDTH bits. This makes 2^WIDTH-1 followed by 0 a correct increment.
- **IDLE** (entered on reset):
  - On the first rising edge after `rst` deasserts: `prev <= q`, `good <= 0`, go to SYNC.
  - No checks in this state.
- **SYNC**:
  - `prev <= q` every edge.
  - If `q == next`: `good <= good + 1`. When `good + 1 == LOCK_CNT`, go to TRACK.
  - Otherwise: `good <= 0`.
  - No `err` and no `wrap_cnt` update in SYNC.
- **TRACK**:
  - `prev <= q` every edge.
  - If `q == next` and `prev == 2^WIDTH-1`: `wrap_cnt` increments (saturating).
  - If `q != next`, including a held value: `err` pulses for one cycle, `err_sticky <= 1`, `err_cnt` increments (saturating), `good <= 0`, state goes to SYNC. Re-lock then needs LOCK_CNT further correct increments.
- `locked` is a registered decode of `state == TRACK`.
- **`clr` priority**:
  - `clr` zeroes `err_sticky`, `err_cnt` and `wrap_cnt`. It does not affect `state`, `prev`, `good` or `locked`.
  - If `clr` coincides with a mismatch: after the edge, `err_cnt == 1` and `err_sticky == 1`.
  - If `clr` coincides with a wrap: after the edge, `wrap_cnt == 1`.
- **Reset**:
  - Asserting `rst` at any time, mid-TRACK included, immediately forces: state IDLE, `prev = 0`, `good = 0`, `locked = 0`, `err = 0`, `err_sticky = 0`, `err_cnt = 0`, `wrap_cnt = 0`.

## Timing
- All outputs are registered; no combinational path from `q` or `clr` to any output.
- Latency is one clock. A mismatching `q` sampled at edge k makes `err` high from edge k to edge k+1 and updates `err_cnt`/`err_sticky` at edge k. A wrap sampled at edge k updates `wrap_cnt` at edge k.
- Minimum lock time after reset release is LOCK_CNT+1 edges. With defaults, samples 0,1,2 give `locked = 1` after the third edge.
- Back-to-back mismatches cannot give consecutive `err` pulses: the first mismatch drops the block to SYNC, and SYNC never reports errors.
- Saturation: at 2^ERR_W-1, further events leave the counter unchanged. `err` still pulses and `err_sticky` stays 1.

## Test plan
- **Reset and lock:** hold `rst = 0` for 3 cycles, release; counter runs 0,1,2,3… → all outputs 0 during reset; `locked` rises after the 3rd post-reset edge; `err` stays 0.
- **Clean wrap:** locked counter runs 13,14,15,0,1 → `wrap_cnt = 1`, `err_cnt = 0`. 40 full periods → `wrap_cnt = 40`.
- **Single fault:** force `q = 9` where 6 is expected → one-cycle `err`; `err_cnt = 1`, `err_sticky = 1`, `locked` drops. Resume 10,11 → `locked` again after 2 correct increments.
- **Stuck value:** hold `q = 5` for 4 cycles while locked → exactly one `err` pulse, `err_cnt = 1`, block stays in SYNC with `locked = 0` until 6,7 follow.
- **Clear versus event:** with `err_cnt = 3`, assert `clr` on the same edge as a mismatch → `err_cnt = 1`, `err_sticky = 1`. With `err_cnt = 3`, assert `clr` alone → `err_cnt = 0`, `err_sticky = 0`, `locked` unchanged.
- **Saturation and mid-run reset:** with ERR_W = 2, inject 5 separate faults → `err_cnt = 3`. Then pull `rst` low mid-TRACK → every output reads 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_monitor.sv
// counter_monitor
//
// Observer for a free-running WIDTH-bit up-counter. Samples q on every rising
// edge, locks onto the incrementing sequence after LOCK_CNT consecutive
// correct increments, and flags any sample that is not the previous sample
// plus one (mod 2^WIDTH) while locked.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   q          in   observed counter value (WIDTH bits)
//   clr        in   synchronous clear of err_sticky, err_cnt, wrap_cnt
//   locked     out  high while in TRACK
//   err        out  one-cycle pulse per mismatch detected in TRACK
//   err_sticky out  set by any err, held until clr or reset
//   err_cnt    out  saturating mismatch count (ERR_W bits)
//   wrap_cnt   out  saturating count of max-to-0 wraps seen in TRACK
//   state_dbg  out  current FSM state (0 IDLE, 1 SYNC, 2 TRACK)

module counter_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] wrap_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] Q_MAX    = '1;
    localparam logic [ERR_W-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] CNT_ONE  = ERR_W'(1);
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_CNT);

    state_t           state, state_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic [3:0]       good, good_n;
    logic             locked_n, err_n, err_sticky_n;
    logic [ERR_W-1:0] err_cnt_n, wrap_cnt_n;

    logic [WIDTH-1:0] next_val;
    logic             match;
    logic             err_ev;
    logic             wrap_ev;

    // Truncating add: Q_MAX followed by 0 counts as a correct increment.
    assign next_val  = prev + WIDTH'(1);
    assign match     = (q == next_val);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev       <= '0;
            good       <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            good       <= good_n;
            locked     <= locked_n;
            err        <= err_n;
            err_sticky <= err_sticky_n;
            err_cnt    <= err_cnt_n;
            wrap_cnt   <= wrap_cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        prev_n  = q;
        good_n  = good;
        err_ev  = 1'b0;
        wrap_ev = 1'b0;

        unique case (state)
            IDLE: begin
                good_n  = '0;
                state_n = SYNC;
            end
            SYNC: begin
                if (match) begin
                    good_n = good + 4'd1;
                    if (good + 4'd1 == LOCK_V) begin
                        state_n = TRACK;
                    end
                end else begin
                    good_n = '0;
                end
            end
            TRACK: begin
                if (match) begin
                    wrap_ev = (prev == Q_MAX);
                end else begin
                    // A held value is a mismatch too; drop back and re-lock.
                    err_ev  = 1'b1;
                    good_n  = '0;
                    state_n = SYNC;
                end
            end
            default: begin
                good_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Outputs: an event on the same edge as clr wins over the clear, so the
    // counter lands on 1 rather than 0.
    always_comb begin
        locked_n     = (state_n == TRACK);
        err_n        = err_ev;
        err_sticky_n = err_sticky;
        err_cnt_n    = err_cnt;
        wrap_cnt_n   = wrap_cnt;

        if (clr) begin
            err_sticky_n = err_ev;
            err_cnt_n    = err_ev  ? CNT_ONE : '0;
            wrap_cnt_n   = wrap_ev ? CNT_ONE : '0;
        end else begin
            if (err_ev) begin
                err_sticky_n = 1'b1;
                if (err_cnt != CNT_MAX) begin
                    err_cnt_n = err_cnt + CNT_ONE;
                end
            end
            if (wrap_ev && (wrap_cnt != CNT_MAX)) begin
                wrap_cnt_n = wrap_cnt + CNT_ONE;
            end
        end
    end

endmodule
